// File: rtl/sa_result_drain.sv
// rtl/sa_result_drain.sv - captures one SA_CORE result vector and serializes its valid rows onto a stream
// Optional SA_DRAIN_STATS_EN adds vec_cnt/stall_cnt statistics counters.
module sa_result_drain #(
  parameter int ROWS = 8,
  parameter int DW   = 32,
  parameter int IDXW = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*DW-1:0]   routport,
  input  logic [ROWS-1:0]      rvalidport,
  output logic                 outread,
  output logic [DW-1:0]        m_data,
  output logic [IDXW-1:0]      m_idx,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy
`ifdef SA_DRAIN_STATS_EN
  ,
  output logic [15:0]          vec_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DW-1:0]     r_data [ROWS];
  logic [ROWS-1:0]   r_mask;
  logic              r_outread;
  logic [IDXW-1:0]   w_idx;
  logic [ROWS-1:0]   w_onehot;
  logic              w_valid;
  logic              w_last;
  logic              w_hs;
  logic              w_capture;

  // Lowest set mask bit is the row currently presented.
  always_comb begin
    w_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (r_mask[i]) w_idx = IDXW'(i);
    end
  end

  assign w_onehot  = ROWS'(1) << w_idx;
  assign w_valid   = (r_state == S_DRAIN);
  assign w_last    = w_valid && ((r_mask & ~w_onehot) == '0);
  assign w_hs      = w_valid && m_ready;
  assign w_capture = (r_state == S_IDLE) && (|rvalidport);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_capture) w_next = S_DRAIN;
      S_DRAIN: if (w_hs && w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_outread <= 1'b0;
      for (int i = 0; i < ROWS; i++) r_data[i] <= '0;
    end else begin
      r_state   <= w_next;
      r_outread <= w_capture;
      if (w_capture) begin
        r_mask <= rvalidport;
        for (int i = 0; i < ROWS; i++) r_data[i] <= routport[i*DW +: DW];
      end else if (w_hs) begin
        r_mask <= r_mask & ~w_onehot;
      end
    end
  end

  // Outputs are forced to zero in IDLE so stale captured words never leak onto the stream.
  assign outread = r_outread;
  assign m_valid = w_valid;
  assign m_idx   = w_valid ? w_idx : '0;
  assign m_data  = w_valid ? r_data[w_idx] : '0;
  assign m_last  = w_last;
  assign busy    = (r_state != S_IDLE);

`ifdef SA_DRAIN_STATS_EN
  logic [15:0] r_vec_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_hs && w_last)        r_vec_cnt   <= r_vec_cnt + 16'd1;
      if (w_valid && !m_ready)   r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign vec_cnt   = r_vec_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
